// File: rtl/pc_branch_ctrl_if.sv
// Bus bundle for pc_branch_ctrl: control/branch inputs, LUT write port and
// the registered fetch-side outputs. The optional branch counter signal is
// present only when BRANCH_CNT_EN is defined.
interface pc_branch_ctrl_if #(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned LUT_IDX_W = 4
);

  // Sequencing and branch-resolution inputs
  logic                 start;
  logic                 branch_en;
  logic                 branch_ne;
  logic                 equal;
  logic [LUT_IDX_W-1:0] lut_idx;
  logic                 halt_req;

  // Branch-target LUT write port
  logic                 lut_wr_en;
  logic [LUT_IDX_W-1:0] lut_wr_idx;
  logic [PC_W-1:0]      lut_wr_data;

  // Registered outputs
  logic [PC_W-1:0]      prog_ctr;
  logic                 taken;
  logic                 done;
`ifdef BRANCH_CNT_EN
  logic [15:0]          branch_cnt;
`endif

  // Driver side (decode/control logic or a testbench)
  modport master (
    output start, branch_en, branch_ne, equal, lut_idx, halt_req,
    output lut_wr_en, lut_wr_idx, lut_wr_data,
`ifdef BRANCH_CNT_EN
    input  branch_cnt,
`endif
    input  prog_ctr, taken, done
  );

  // PC/branch stage side
  modport slave (
    input  start, branch_en, branch_ne, equal, lut_idx, halt_req,
    input  lut_wr_en, lut_wr_idx, lut_wr_data,
`ifdef BRANCH_CNT_EN
    output branch_cnt,
`endif
    output prog_ctr, taken, done
  );

endinterface

// File: rtl/pc_branch_ctrl.sv
// Program-counter and branch-resolution stage for the 8-bit datapath.
// Runs an IDLE/RUN/HALT sequencer, steps the fetch address each RUN cycle,
// and redirects it through a programmable branch-target LUT when a beq/bne
// resolves taken. Branch decisions are combinational on the current cycle's
// inputs; the redirected fetch address appears one cycle later.
// Optional feature macro: BRANCH_CNT_EN (adds a saturating 16-bit count of
// taken branches since the last reset or start).
module pc_branch_ctrl #(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned LUT_IDX_W = 4
) (
  input logic              i_clk,
  input logic              i_reset,
  pc_branch_ctrl_if.slave  bus
);

  localparam int unsigned LutDepth = 2 ** LUT_IDX_W;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic            r_taken;
  logic            w_taken_nxt;
  logic            r_done;
  logic            w_done_nxt;

  logic [PC_W-1:0] r_lut [LutDepth];

  logic            w_cond;
  logic            w_branch_take;
  logic [PC_W-1:0] w_lut_target;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_cnt_clr;
  logic            w_cnt_inc;

  // Branch condition: bne takes on inequality, beq on equality
  assign w_cond        = bus.branch_ne ? ~bus.equal : bus.equal;
  assign w_branch_take = bus.branch_en & w_cond;

  // LUT read sees the pre-write contents, giving read-before-write on a
  // same-index collision
  assign w_lut_target  = r_lut[bus.lut_idx];

  // Natural PC_W-bit overflow gives the wrap from all-ones to zero
  assign w_pc_inc      = r_pc + PC_W'(1);

  // Sequencer next-state and next-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_taken_nxt = r_taken;
    w_done_nxt  = r_done;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;

    unique case (r_state)
      StIdle: begin
        // Branch and halt inputs have no effect until a program is started
        w_pc_nxt    = '0;
        w_taken_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        if (bus.start) begin
          w_state_nxt = StRun;
          w_cnt_clr   = 1'b1;
        end
      end

      StRun: begin
        // Halt outranks a taken branch on the same instruction
        if (bus.halt_req) begin
          w_state_nxt = StHalt;
          w_done_nxt  = 1'b1;
          w_taken_nxt = 1'b0;
        end else if (w_branch_take) begin
          w_pc_nxt    = w_lut_target;
          w_taken_nxt = 1'b1;
          w_cnt_inc   = 1'b1;
        end else begin
          w_pc_nxt    = w_pc_inc;
          w_taken_nxt = 1'b0;
        end
      end

      StHalt: begin
        w_taken_nxt = 1'b0;
        w_done_nxt  = 1'b1;
        // Restart the next program from address 0
        if (bus.start) begin
          w_state_nxt = StRun;
          w_pc_nxt    = '0;
          w_done_nxt  = 1'b0;
          w_cnt_clr   = 1'b1;
        end
      end

      default: begin
        // Unreachable encoding: recover to a clean idle
        w_state_nxt = StIdle;
        w_pc_nxt    = '0;
        w_taken_nxt = 1'b0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs, synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_pc    <= '0;
      r_taken <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_taken <= w_taken_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Branch-target LUT: writable in every state, wiped by reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < LutDepth; i++) begin
        r_lut[i] <= '0;
      end
    end else if (bus.lut_wr_en) begin
      r_lut[bus.lut_wr_idx] <= bus.lut_wr_data;
    end
  end

  assign bus.prog_ctr = r_pc;
  assign bus.taken    = r_taken;
  assign bus.done     = r_done;

`ifdef BRANCH_CNT_EN
  logic [15:0] r_branch_cnt;

  // Taken-branch counter: cleared on program start, saturates at all-ones
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_branch_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_branch_cnt <= '0;
    end else if (w_cnt_inc && (r_branch_cnt != 16'hFFFF)) begin
      r_branch_cnt <= r_branch_cnt + 16'd1;
    end
  end

  assign bus.branch_cnt = r_branch_cnt;
`else
  // Counter hooks are only consumed when the counter is built in
  logic w_cnt_unused;
  assign w_cnt_unused = w_cnt_clr ^ w_cnt_inc;
`endif

endmodule
